// File: rtl/kl8e_rx.sv
// Console keyboard receiver: deserializes 8N1 frames from rx into a character
// register and drives the keyboard flag used by the KSF/KRB/KCC IOT handshake.
module kl8e_rx #(
  parameter int clock_frequency = 12000000,
  parameter int baud_rate       = 9600,
  parameter int CLKS_PER_BIT    = clock_frequency / baud_rate
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  input  logic       clear_flag,
  output logic [0:7] rx_data,
  output logic       rx_flag,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             rx_meta_r;
  logic             rx_sync_r;
  logic             rx_dly_r;
  logic [1:0]       warm_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [0:7]       shift_r;

  logic start_edge_s;
  logic tick_s;
  logic load_half_s;
  logic load_full_s;
  logic shift_en_s;
  logic complete_s;

  // The edge detector stays disarmed until the synchronizer holds real line
  // samples, so a line that is already low when reset lifts is not a start.
  assign start_edge_s = (warm_r == 2'd3) & rx_dly_r & ~rx_sync_r;
  assign tick_s       = (cnt_r == CNT_ONE);

  // Two-flop synchronizer, edge-detect flop and post-reset warm-up count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_dly_r  <= 1'b1;
      warm_r    <= 2'd0;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_dly_r  <= rx_sync_r;
      if (warm_r != 2'd3) begin
        warm_r <= warm_r + 2'd1;
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) state_nxt_s = ST_START;
        else              state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (tick_s) state_nxt_s = rx_sync_r ? ST_IDLE : ST_DATA;
        else        state_nxt_s = ST_START;
      end
      ST_DATA: begin
        if (tick_s && (bit_idx_r == 3'd7)) state_nxt_s = ST_STOP;
        else                               state_nxt_s = ST_DATA;
      end
      ST_STOP: begin
        if (tick_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_STOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-state datapath strobes.
  always_comb begin
    load_half_s = 1'b0;
    load_full_s = 1'b0;
    shift_en_s  = 1'b0;
    complete_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) load_half_s = 1'b1;
        else              load_half_s = 1'b0;
      end
      ST_START: begin
        if (tick_s && !rx_sync_r) load_full_s = 1'b1;
        else                      load_full_s = 1'b0;
      end
      ST_DATA: begin
        if (tick_s) begin
          shift_en_s  = 1'b1;
          load_full_s = 1'b1;
        end else begin
          shift_en_s  = 1'b0;
          load_full_s = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick_s) complete_s = 1'b1;
        else        complete_s = 1'b0;
      end
      default: complete_s = 1'b0;
    endcase
  end

  // Baud counter, bit index and shift register; expiry is the cycle at count 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      if (load_half_s)          cnt_r <= HALF_BIT;
      else if (load_full_s)     cnt_r <= FULL_BIT;
      else if (cnt_r != CNT_ZERO) cnt_r <= cnt_r - CNT_ONE;
      else                      cnt_r <= cnt_r;

      if (state_r == ST_START) bit_idx_r <= 3'd0;
      else if (shift_en_s)     bit_idx_r <= bit_idx_r + 3'd1;
      else                     bit_idx_r <= bit_idx_r;

      // First wire bit ends up in index 7, the LSB.
      if (shift_en_s) shift_r <= {rx_sync_r, shift_r[0:6]};
      else            shift_r <= shift_r;
    end
  end

  // Registered outputs; on a completion that coincides with clear_flag the
  // flag is treated as cleared first, so it sets again without an overrun.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_data     <= 8'h00;
      rx_flag     <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy <= (state_nxt_s != ST_IDLE);
      if (complete_s) begin
        rx_data     <= shift_r;
        framing_err <= ~rx_sync_r;
        overrun     <= rx_flag & ~clear_flag;
        rx_flag     <= 1'b1;
      end else if (clear_flag) begin
        rx_flag <= 1'b0;
        overrun <= 1'b0;
      end else begin
        rx_flag <= rx_flag;
        overrun <= overrun;
      end
    end
  end

endmodule

// File: tb/tb_kl8e_rx.sv
// Directed bench for kl8e_rx with CLKS_PER_BIT = 16 and hand-computed results.
module tb_kl8e_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       resetn;
  logic       rx;
  logic       clear_flag;
  logic [0:7] rx_data;
  logic       rx_flag;
  logic       framing_err;
  logic       overrun;
  logic       busy;

  int checks;
  int errors;
  int lat_meas;

  kl8e_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rx          (rx),
    .clear_flag  (clear_flag),
    .rx_data     (rx_data),
    .rx_flag     (rx_flag),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_frame(input logic [7:0] ch, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = ch[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_flag = 1'b1;
    @(negedge clk);
    clear_flag = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    rx = 1'b0;
    clear_flag = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    checks++; if (rx_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b expected 0", rx_flag); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", framing_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_low_no_start: busy got %b expected 0", busy); end
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    logic busy_mid;
    lat = 0;
    busy_mid = 1'b0;
    fork
      send_frame(8'h41, 1'b1);
      begin
        @(negedge rx);
        while (lat < 400) begin
          @(posedge clk);
          lat++;
          #1;
          if (lat == 80) busy_mid = busy;
          if (rx_flag) break;
        end
      end
    join
    lat_meas = lat;
    checks++; if (lat < 152 || lat > 156) begin errors++; $display("FAIL basic_latency: got %0d clks expected 152..156", lat); end
    checks++; if (rx_data !== 8'h41) begin errors++; $display("FAIL basic_data: got %h expected 41", rx_data); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b expected 0", framing_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_ovr: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b expected 1", busy_mid); end
    pulse_clear();
    checks++; if (rx_flag !== 1'b0) begin errors++; $display("FAIL basic_clear: flag got %b expected 0", rx_flag); end
  endtask

  task automatic test_glitch();
    repeat (2 * CPB) @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start: busy got %b expected 1", busy); end
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: busy got %b expected 0", busy); end
    checks++; if (rx_flag !== 1'b0) begin errors++; $display("FAIL glitch_flag: got %b expected 0", rx_flag); end
    checks++; if (rx_data !== 8'h41) begin errors++; $display("FAIL glitch_data: got %h expected 41", rx_data); end
  endtask

  task automatic test_framing();
    send_frame(8'h55, 1'b0);
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL ferr_data: got %h expected 55", rx_data); end
    checks++; if (framing_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b expected 1", framing_err); end
    checks++; if (rx_flag !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", rx_flag); end
    pulse_clear();
    checks++; if (framing_err !== 1'b1) begin errors++; $display("FAIL ferr_held: got %b expected 1", framing_err); end
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h0A, 1'b1);
    checks++; if (rx_data !== 8'h0A) begin errors++; $display("FAIL ferr_next_data: got %h expected 0a", rx_data); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b expected 0", framing_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ferr_next_ovr: got %b expected 0", overrun); end
    pulse_clear();
  endtask

  task automatic test_back_to_back();
    send_frame(8'hC3, 1'b1);
    checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL b2b_first_data: got %h expected c3", rx_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_first_ovr: got %b expected 0", overrun); end
    send_frame(8'h7E, 1'b1);
    checks++; if (rx_data !== 8'h7E) begin errors++; $display("FAIL b2b_second_data: got %h expected 7e", rx_data); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
    checks++; if (rx_flag !== 1'b1) begin errors++; $display("FAIL b2b_flag: got %b expected 1", rx_flag); end
    pulse_clear();
    checks++; if (rx_flag !== 1'b0) begin errors++; $display("FAIL b2b_clr_flag: got %b expected 0", rx_flag); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_clr_ovr: got %b expected 0", overrun); end
    checks++; if (rx_data !== 8'h7E) begin errors++; $display("FAIL b2b_clr_data: got %h expected 7e", rx_data); end
  endtask

  task automatic test_simultaneous();
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h80, 1'b1);
      begin
        @(negedge rx);
        repeat (lat_meas - 1) @(posedge clk);
        @(negedge clk);
        clear_flag = 1'b1;
        @(negedge clk);
        clear_flag = 1'b0;
      end
    join
    checks++; if (rx_flag !== 1'b1) begin errors++; $display("FAIL simul_flag: got %b expected 1", rx_flag); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL simul_ovr: got %b expected 0", overrun); end
    checks++; if (rx_data !== 8'h80) begin errors++; $display("FAIL simul_data: got %h expected 80", rx_data); end
    pulse_clear();
  endtask

  task automatic test_reset_abort();
    repeat (2 * CPB) @(negedge clk);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(negedge rx);
        repeat (60) @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_rst: got %b expected 0", busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL abort_data_rst: got %h expected 00", rx_data); end
        resetn = 1'b1;
      end
    join
    repeat (CPB) @(negedge clk);
    checks++; if (rx_flag !== 1'b0) begin errors++; $display("FAIL abort_flag: got %b expected 0", rx_flag); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    send_frame(8'h33, 1'b1);
    checks++; if (rx_data !== 8'h33) begin errors++; $display("FAIL abort_next_data: got %h expected 33", rx_data); end
    checks++; if (rx_flag !== 1'b1) begin errors++; $display("FAIL abort_next_flag: got %b expected 1", rx_flag); end
    checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL abort_next_ferr: got %b expected 0", framing_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL abort_next_ovr: got %b expected 0", overrun); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    lat_meas = 155;
    resetn = 1'b0;
    rx = 1'b1;
    clear_flag = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_simultaneous();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
